// File: rtl/fetch_pkg.sv
// Shared fetch types and memory-map constants used by the fetch stage and the memory system.
package fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE         = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; write visible at head one cycle after push, flush beats push/pop.
// Caller must not push when full unless popping in the same cycle; head is raw storage when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC drives memory each cycle, {pc, instr} buffered for decode (1-cycle address-to-valid, stalls when full).
// Redirect flushes and reloads the PC; FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] fetch_addr_o,
  input  logic [DATA_WIDTH-1:0] fetch_data_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  fault_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  push, pop, full, empty;
  logic [CW-1:0]         count;
  fetch_entry_t          wr_entry, head;

  assign pop  = instr_valid_o && instr_ready_i;
  assign push = !redirect_i && !fault_o && (!full || pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = fetch_data_i;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i (wr_entry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;

  assign misaligned      = (redirect_pc_i[1:0] != 2'b00);
  // A faulting redirect keeps the raw target so it is visible on fetch_addr_o.
  assign redirect_target = misaligned ? redirect_pc_i : (redirect_pc_i & ~DATA_WIDTH'(3));

  always_comb begin
    fault_d = fault_q;
    if (redirect_i) fault_d = misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault_o = fault_q;
`else
  assign redirect_target = redirect_pc_i & ~DATA_WIDTH'(3);
  assign fault_o         = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = redirect_target;
    else if (push)   pc_d = pc_q + DATA_WIDTH'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign fetch_addr_o  = pc_q;
  assign instr_valid_o = (count != '0) && !redirect_i;
  assign instr_o       = empty ? '0 : head.instr;
  assign instr_pc_o    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised and directed stimulus against a queue-based fetch model; a separate monitor checks every cycle.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr_o;
  logic [31:0] fetch_data_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  int          m_cnt = 0;
  logic [31:0] m_pc = RST_PC;
  logic        m_fault = 1'b0;
  logic        mon_vld;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_data_i  (fetch_data_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fault_o       (fault_o)
  );

  // Memory returns a deterministic pattern for every address.
  assign fetch_data_i = fetch_addr_o ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances the architectural picture by one clock edge.
  task automatic model_edge();
    bit do_pop, do_push;
    if (reset) begin
      m_pc = RST_PC; m_cnt = 0; m_fault = 1'b0; exp_q.delete();
    end else if (redirect_i) begin
      m_cnt = 0; exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_fault = (redirect_pc_i % 4) != 0;
      m_pc    = m_fault ? redirect_pc_i : redirect_pc_i - (redirect_pc_i % 4);
`else
      m_pc    = redirect_pc_i - (redirect_pc_i % 4);
`endif
    end else begin
      do_pop  = (m_cnt != 0) && instr_ready_i;
      do_push = !m_fault && (m_cnt < DEPTH || do_pop);
      if (do_push) begin
        exp_q.push_back('{pc: m_pc, instr: m_pc ^ 32'hA5A5_0000});
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + int'(do_push) - int'(do_pop);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; instr_ready_i = rdy; redirect_i = rdr; redirect_pc_i = rpc;
    #2;
    model_edge();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0);
  endtask

  // Monitor: compares what the DUT presents against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        chk("fetch_addr", fetch_addr_o, m_pc);
        chk("fault", 32'(fault_o), 32'(m_fault));
        mon_vld = (exp_q.size() != 0) && !redirect_i;
        chk("valid", 32'(instr_valid_o), 32'(mon_vld));
        if (exp_q.size() == 0) begin
          chk("empty_instr", instr_o, 32'h0);
          chk("empty_pc", instr_pc_o, 32'h0);
        end else if (mon_vld) begin
          chk("head_pc", instr_pc_o, exp_q[0].pc);
          chk("head_instr", instr_o, exp_q[0].instr);
          if (instr_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Fill with decode stalled.
    idle(6, 1'b0);
    chk("fill_addr", fetch_addr_o, 32'h0040_0010);
    chk("fill_valid", 32'(instr_valid_o), 32'h1);
    chk("fill_head_pc", instr_pc_o, 32'h0040_0000);

    // Streaming.
    idle(50, 1'b1);

    // Redirect from full.
    idle(6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1000_0040);
    chk("redir_valid", 32'(instr_valid_o), 32'h0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("redir_addr", fetch_addr_o, 32'h1000_0040);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("redir_first_pc", instr_pc_o, 32'h1000_0040);
    idle(3, 1'b1);

    // Full with a single pop pulse.
    idle(6, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    idle(3, 1'b0);

    // PC wrap.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pc0", instr_pc_o, 32'hFFFF_FFF8);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pc1", instr_pc_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pc2", instr_pc_o, 32'h0000_0000);

    // Misaligned redirect.
    step(1'b0, 1'b1, 1'b1, 32'h0040_0102);
    step(1'b0, 1'b1, 1'b0, '0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(fault_o), 32'h1);
    chk("mis_addr", fetch_addr_o, 32'h0040_0102);
    idle(4, 1'b1);
    chk("mis_no_valid", 32'(instr_valid_o), 32'h0);
`else
    chk("mis_addr", fetch_addr_o, 32'h0040_0100);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("mis_pc", instr_pc_o, 32'h0040_0100);
    idle(3, 1'b1);
`endif
    step(1'b0, 1'b1, 1'b1, 32'h0040_0000);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("clear_fault", 32'(fault_o), 32'h0);
    idle(3, 1'b1);

    // Reset mid-stream.
    idle(5, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_addr", fetch_addr_o, RST_PC);
    chk("rst_instr", instr_o, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = $urandom & 32'hFFFF_FFFC;
        2:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: rpc = RST_PC + ($urandom & 32'hFC);
      endcase
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 11) == 0), rpc);
    end

    idle(2, 1'b1);
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
